// File: rtl/rv64_pkg.sv
// Shared definitions for the RV64I-subset single-cycle core:
// data width, opcode / funct constants, ALU operation encoding and
// the ALU evaluation helper.
package rv64_pkg;

  localparam int unsigned XLEN = 64;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_DOUBLE  = 3'b011;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR
  } alu_op_e;

  function automatic logic [XLEN-1:0] alu_eval(input alu_op_e op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [XLEN-1:0] result;
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      default: result = '0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/rv64_regfile.sv
// 32 x XLEN register file: two combinational read ports, one write port
// at the rising edge. x0 reads as zero and ignores writes.
// Ports:
//   clk           system clock
//   reset         asynchronous active-low reset, clears all registers
//   rs1, rs2      read addresses
//   rd            write address
//   write_enable  write strobe
//   write_data    write value
//   read_data1/2  read values for rs1 / rs2
module rv64_regfile
  import rv64_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic            write_enable,
  input  logic [XLEN-1:0] write_data,
  output logic [XLEN-1:0] read_data1,
  output logic [XLEN-1:0] read_data2
);

  logic [XLEN-1:0] registers [32];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 32; i++) begin
        registers[i] <= '0;
      end
    end else if (write_enable && (rd != 5'd0)) begin
      registers[rd] <= write_data;
    end
  end

  assign read_data1 = (rs1 == 5'd0) ? '0 : registers[rs1];
  assign read_data2 = (rs2 == 5'd0) ? '0 : registers[rs2];

endmodule

// File: rtl/rv64_cpu_sequential.sv
// Single-cycle RV64I-subset core (addi, add, sub, and, or, ld, sd, beq)
// with internal instruction memory, data memory and register file.
// Memories are loaded and inspected through hierarchical references
// (imem.memory, dmem.memory, reg_file.registers); reset leaves them intact.
// Ports:
//   clk    system clock, all state updates on the rising edge
//   reset  asynchronous active-low reset (PC and registers cleared)
module rv64_cpu_sequential
  import rv64_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned DMEM_DEPTH = 256
) (
  input logic clk,
  input logic reset
);

  localparam int unsigned IMEM_AW = $clog2(IMEM_DEPTH);
  localparam int unsigned DMEM_AW = $clog2(DMEM_DEPTH);

  logic [XLEN-1:0] pc_current;
  logic [XLEN-1:0] pc_next;
  logic [31:0]     instruction;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;

  logic            reg_write;
  logic            mem_read;
  logic            mem_write;
  logic            branch;
  logic            use_imm;
  alu_op_e         alu_op;

  logic [XLEN-1:0] i_imm;
  logic [XLEN-1:0] s_imm;
  logic [XLEN-1:0] b_imm;
  logic [XLEN-1:0] imm;

  logic [XLEN-1:0] reg_read_data1;
  logic [XLEN-1:0] reg_read_data2;
  logic [XLEN-1:0] alu_operand_b;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] mem_read_data;
  logic [XLEN-1:0] reg_write_data;
  logic            branch_taken;

  logic [IMEM_AW-1:0] imem_index;
  logic [DMEM_AW-1:0] dmem_index;

  // Fetch: word index wraps naturally since only the in-range PC bits are used.
  assign imem_index = pc_current[IMEM_AW+1:2];

  if (1) begin : imem
    logic [31:0] memory [IMEM_DEPTH];
  end

  assign instruction = imem.memory[imem_index];

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign funct7 = instruction[31:25];

  assign i_imm = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
  assign s_imm = {{(XLEN-12){instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign b_imm = {{(XLEN-13){instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};

  // Decode: anything not matched below leaves every strobe low (NOP, pc+4).
  always_comb begin
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    branch    = 1'b0;
    use_imm   = 1'b0;
    alu_op    = ALU_ADD;
    imm       = i_imm;
    case (opcode)
      OP_IMM: begin
        if (funct3 == F3_ADD_SUB) begin
          reg_write = 1'b1;
          use_imm   = 1'b1;
        end
      end
      OP: begin
        if (funct3 == F3_ADD_SUB && funct7 == F7_ADD) begin
          reg_write = 1'b1;
          alu_op    = ALU_ADD;
        end else if (funct3 == F3_ADD_SUB && funct7 == F7_SUB) begin
          reg_write = 1'b1;
          alu_op    = ALU_SUB;
        end else if (funct3 == F3_AND) begin
          reg_write = 1'b1;
          alu_op    = ALU_AND;
        end else if (funct3 == F3_OR) begin
          reg_write = 1'b1;
          alu_op    = ALU_OR;
        end
      end
      LOAD: begin
        if (funct3 == F3_DOUBLE) begin
          reg_write = 1'b1;
          mem_read  = 1'b1;
          use_imm   = 1'b1;
        end
      end
      STORE: begin
        if (funct3 == F3_DOUBLE) begin
          mem_write = 1'b1;
          use_imm   = 1'b1;
          imm       = s_imm;
        end
      end
      BRANCH: begin
        if (funct3 == F3_BEQ) begin
          branch = 1'b1;
          alu_op = ALU_SUB;
        end
      end
      default: ;
    endcase
  end

  rv64_regfile reg_file (
    .clk          (clk),
    .reset        (reset),
    .rs1          (rs1),
    .rs2          (rs2),
    .rd           (rd),
    .write_enable (reg_write),
    .write_data   (reg_write_data),
    .read_data1   (reg_read_data1),
    .read_data2   (reg_read_data2)
  );

  assign alu_operand_b = use_imm ? imm : reg_read_data2;
  assign alu_result    = alu_eval(alu_op, reg_read_data1, alu_operand_b);

  // Doubleword index: low 3 address bits dropped, upper bits wrap.
  assign dmem_index = alu_result[DMEM_AW+2:3];

  if (1) begin : dmem
    logic [XLEN-1:0] memory [DMEM_DEPTH];

    always_ff @(posedge clk) begin
      if (mem_write) begin
        memory[dmem_index] <= reg_read_data2;
      end
    end
  end

  assign mem_read_data  = dmem.memory[dmem_index];
  assign reg_write_data = mem_read ? mem_read_data : alu_result;

  assign branch_taken = branch && (alu_result == '0);
  assign pc_next      = branch_taken ? (pc_current + b_imm) : (pc_current + 64'd4);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_current <= '0;
    end else begin
      pc_current <= pc_next;
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, pc_current[XLEN-1:IMEM_AW+2], pc_current[1:0],
                       alu_result[XLEN-1:DMEM_AW+3], alu_result[2:0]};

endmodule

// File: tb/tb_rv64_cpu_sequential.sv
module tb_rv64_cpu_sequential;

  logic clk;
  logic reset;

  int checks;
  int failures;

  rv64_cpu_sequential #(
    .IMEM_DEPTH (256),
    .DMEM_DEPTH (256)
  ) dut (
    .clk   (clk),
    .reset (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  localparam logic [63:0] PRELOAD5 = 64'hDEAD_BEEF_0123_4567;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;

    for (int i = 0; i < 256; i++) begin
      dut.imem.memory[i] = 32'h0000_007F;
      dut.dmem.memory[i] = 64'd0;
    end
    dut.imem.memory[0]  = 32'h00A0_0093; // addi x1,x0,10
    dut.imem.memory[1]  = 32'h00B0_0113; // addi x2,x0,11
    dut.imem.memory[2]  = 32'h0020_81B3; // add  x3,x1,x2
    dut.imem.memory[3]  = 32'h4020_8233; // sub  x4,x1,x2
    dut.imem.memory[4]  = 32'h0020_F2B3; // and  x5,x1,x2
    dut.imem.memory[5]  = 32'h0020_E333; // or   x6,x1,x2
    dut.imem.memory[6]  = 32'h0030_3423; // sd   x3,8(x0)
    dut.imem.memory[7]  = 32'h0080_3383; // ld   x7,8(x0)
    dut.imem.memory[8]  = 32'h0050_0013; // addi x0,x0,5
    dut.imem.memory[9]  = 32'h0010_8463; // beq  x1,x1,8   (pc 0x24 -> 0x2C)
    dut.imem.memory[10] = 32'h0000_007F; // skipped
    dut.imem.memory[11] = 32'h0020_8463; // beq  x1,x2,8   (pc 0x2C -> 0x30)
    dut.imem.memory[12] = 32'h0000_007F; // NOP
    dut.dmem.memory[5]  = PRELOAD5;

    // Reset held for two edges
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_pc", dut.pc_current, 64'd0);
    for (int i = 1; i <= 7; i++) begin
      check($sformatf("reset_x%0d", i), dut.reg_file.registers[i], 64'd0);
    end
    check("reset_dmem5", dut.dmem.memory[5], PRELOAD5);
    check("reset_imem0", {32'd0, dut.imem.memory[0]}, 64'h0000_0000_00A0_0093);
    check("fetch_instr0", {32'd0, dut.instruction}, 64'h0000_0000_00A0_0093);
    check("decode_rd0", {59'd0, dut.rd}, 64'd1);
    check("regwrite_addi", {63'd0, dut.reg_write}, 64'd1);
    reset = 1'b1;

    // ALU program
    @(posedge clk); @(negedge clk);
    check("x1", dut.reg_file.registers[1], 64'd10);
    check("pc_4", dut.pc_current, 64'h4);
    @(posedge clk); @(negedge clk);
    check("x2", dut.reg_file.registers[2], 64'd11);
    check("pc_8", dut.pc_current, 64'h8);
    @(posedge clk); @(negedge clk);
    check("x3", dut.reg_file.registers[3], 64'd21);
    check("pc_c", dut.pc_current, 64'hC);
    @(posedge clk); @(negedge clk);
    check("x4", dut.reg_file.registers[4], 64'hFFFF_FFFF_FFFF_FFFF);
    check("pc_10", dut.pc_current, 64'h10);
    @(posedge clk); @(negedge clk);
    check("x5", dut.reg_file.registers[5], 64'd10);
    check("pc_14", dut.pc_current, 64'h14);
    @(posedge clk); @(negedge clk);
    check("x6", dut.reg_file.registers[6], 64'd11);
    check("pc_18", dut.pc_current, 64'h18);

    // sd x3,8(x0)
    check("sd_mem_write", {63'd0, dut.mem_write}, 64'd1);
    check("sd_mem_read", {63'd0, dut.mem_read}, 64'd0);
    check("sd_reg_write", {63'd0, dut.reg_write}, 64'd0);
    check("sd_alu_result", dut.alu_result, 64'd8);
    check("sd_rd2", dut.reg_read_data2, 64'd21);
    @(posedge clk); @(negedge clk);
    check("dmem1", dut.dmem.memory[1], 64'd21);
    check("pc_1c", dut.pc_current, 64'h1C);

    // ld x7,8(x0)
    check("ld_mem_read", {63'd0, dut.mem_read}, 64'd1);
    check("ld_mem_write", {63'd0, dut.mem_write}, 64'd0);
    check("ld_mem_read_data", dut.mem_read_data, 64'd21);
    check("ld_wdata", dut.reg_write_data, 64'd21);
    @(posedge clk); @(negedge clk);
    check("x7", dut.reg_file.registers[7], 64'd21);
    check("pc_20", dut.pc_current, 64'h20);

    // addi x0,x0,5
    check("x0w_mem_read", {63'd0, dut.mem_read}, 64'd0);
    check("x0w_mem_write", {63'd0, dut.mem_write}, 64'd0);
    @(posedge clk); @(negedge clk);
    check("x0_zero", dut.reg_file.registers[0], 64'd0);
    check("pc_24", dut.pc_current, 64'h24);

    // beq taken
    check("beq_branch", {63'd0, dut.branch}, 64'd1);
    check("beq_reg_write", {63'd0, dut.reg_write}, 64'd0);
    @(posedge clk); @(negedge clk);
    check("beq_taken_pc", dut.pc_current, 64'h2C);

    // beq not taken
    check("beq_nt_branch", {63'd0, dut.branch}, 64'd1);
    @(posedge clk); @(negedge clk);
    check("beq_not_taken_pc", dut.pc_current, 64'h30);

    // 0x7F NOP
    check("nop_instr", {32'd0, dut.instruction}, 64'h0000_0000_0000_007F);
    check("nop_reg_write", {63'd0, dut.reg_write}, 64'd0);
    check("nop_mem_write", {63'd0, dut.mem_write}, 64'd0);
    @(posedge clk); @(negedge clk);
    check("nop_pc", dut.pc_current, 64'h34);
    check("nop_x1", dut.reg_file.registers[1], 64'd10);
    check("nop_x3", dut.reg_file.registers[3], 64'd21);
    check("nop_x7", dut.reg_file.registers[7], 64'd21);
    check("nop_dmem1", dut.dmem.memory[1], 64'd21);

    // Mid-run reset pulse between edges
    #2 reset = 1'b0;
    #1;
    check("midrst_pc", dut.pc_current, 64'd0);
    for (int i = 1; i <= 31; i++) begin
      check($sformatf("midrst_x%0d", i), dut.reg_file.registers[i], 64'd0);
    end
    check("midrst_dmem1", dut.dmem.memory[1], 64'd21);
    check("midrst_dmem5", dut.dmem.memory[5], PRELOAD5);
    #1 reset = 1'b1;

    // Re-execution after release
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("rerun_pc", dut.pc_current, 64'h18);
    check("rerun_x1", dut.reg_file.registers[1], 64'd10);
    check("rerun_x2", dut.reg_file.registers[2], 64'd11);
    check("rerun_x3", dut.reg_file.registers[3], 64'd21);
    check("rerun_x4", dut.reg_file.registers[4], 64'hFFFF_FFFF_FFFF_FFFF);
    check("rerun_x5", dut.reg_file.registers[5], 64'd10);
    check("rerun_x6", dut.reg_file.registers[6], 64'd11);
    check("rerun_x7", dut.reg_file.registers[7], 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
